// File: rtl/ks_xor_packer.sv
// ks_xor_packer: keystream consumer. After each start it drops WARMUP keystream
// bits, packs the next DATA_W bits MSB-first into a word, XORs that word with
// one plaintext word and offers the ciphertext on a valid/ready output.
// Every word is built from fresh keystream; no bit is used twice.
module ks_xor_packer #(
    parameter int DATA_W = 8,
    parameter int WARMUP = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              ks_bit,
    input  logic              ks_valid,
    output logic              ks_ready,
    input  logic [DATA_W-1:0] pt_data,
    input  logic              pt_valid,
    output logic              pt_ready,
    output logic [DATA_W-1:0] ct_data,
    output logic              ct_valid,
    input  logic              ct_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WARM    = 3'd1;
    localparam logic [2:0] S_FILL    = 3'd2;
    localparam logic [2:0] S_WAIT_PT = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;

    // With no warm-up the session goes straight to packing.
    localparam logic [2:0] S_FIRST = (WARMUP == 0) ? S_FILL : S_WARM;

    // One counter serves both the warm-up run and the packing run, so it is
    // sized for the longer of the two.
    localparam int CNT_MAX = (WARMUP > DATA_W) ? WARMUP : DATA_W;
    localparam int BIT_W   = $clog2(CNT_MAX + 1);

    // Count value held when the final bit of each run is accepted.
    localparam logic [BIT_W-1:0] WARM_LAST = BIT_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [BIT_W-1:0] FILL_LAST = BIT_W'(DATA_W - 1);

    logic [2:0]        state;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] ks_word;

    logic ks_fire;
    logic pt_fire;
    logic ct_fire;

    // Ready signals depend on state only, so they never combinationally
    // follow the upstream valid inputs.
    assign ks_ready = (state == S_WARM) || (state == S_FILL);
    assign pt_ready = (state == S_WAIT_PT);
    assign busy     = (state != S_IDLE);

    assign ks_fire = ks_valid & ks_ready;
    assign pt_fire = pt_valid & pt_ready;
    assign ct_fire = ct_valid & ct_ready;

    // Session state machine, bit counting, keystream packing and ciphertext register.
    always_ff @(posedge clk) begin
        // NOTE: every register here, including the data-path ones, is
        // cleared by reset so a reset mid-session leaves no partial word behind;
        // non-blocking assignments keep all updates tied to the same edge.
        if (!reset) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            ks_word  <= '0;
            ct_data  <= '0;
            ct_valid <= 1'b0;
            word_cnt <= '0;
        end else if (stop && (state != S_IDLE)) begin
            // Abort wins over any handshake in the same cycle; a pending
            // ciphertext word is dropped without being counted.
            state    <= S_IDLE;
            bit_cnt  <= '0;
            ct_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        state   <= S_FIRST;
                        bit_cnt <= '0;
                    end
                end

                S_WARM: begin
                    if (ks_fire) begin
                        if (bit_cnt == WARM_LAST) begin
                            state   <= S_FILL;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end

                S_FILL: begin
                    if (ks_fire) begin
                        // First accepted bit ends up in the MSB after DATA_W shifts.
                        ks_word <= {ks_word[DATA_W-2:0], ks_bit};
                        if (bit_cnt == FILL_LAST) begin
                            state   <= S_WAIT_PT;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end

                S_WAIT_PT: begin
                    if (pt_fire) begin
                        ct_data  <= pt_data ^ ks_word;
                        ct_valid <= 1'b1;
                        state    <= S_OUT;
                    end
                end

                S_OUT: begin
                    // ct_data is untouched here, so it stays stable under backpressure.
                    if (ct_fire) begin
                        ct_valid <= 1'b0;
                        word_cnt <= word_cnt + CNT_W'(1);
                        bit_cnt  <= '0;
                        state    <= S_FILL;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    bit_cnt  <= '0;
                    ct_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ks_xor_packer.sv
// Directed bench for ks_xor_packer. Main instance: DATA_W=8, WARMUP=4.
// Corner instance: WARMUP=0, CNT_W=2 for MSB placement and counter wrap.
module tb_ks_xor_packer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Main instance signals
    logic       reset, start, stop, ks_bit, ks_valid, ks_ready;
    logic [7:0] pt_data;
    logic       pt_valid, pt_ready;
    logic [7:0] ct_data;
    logic       ct_valid, ct_ready, busy;
    logic [15:0] word_cnt;

    // Corner instance signals
    logic       z_reset, z_start, z_stop, z_ks_bit, z_ks_valid, z_ks_ready;
    logic [7:0] z_pt_data;
    logic       z_pt_valid, z_pt_ready;
    logic [7:0] z_ct_data;
    logic       z_ct_valid, z_ct_ready, z_busy;
    logic [1:0] z_word_cnt;

    ks_xor_packer #(.DATA_W(8), .WARMUP(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .ks_bit(ks_bit), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .busy(busy), .word_cnt(word_cnt)
    );

    ks_xor_packer #(.DATA_W(8), .WARMUP(0), .CNT_W(2)) dut_z (
        .clk(clk), .reset(z_reset), .start(z_start), .stop(z_stop),
        .ks_bit(z_ks_bit), .ks_valid(z_ks_valid), .ks_ready(z_ks_ready),
        .pt_data(z_pt_data), .pt_valid(z_pt_valid), .pt_ready(z_pt_ready),
        .ct_data(z_ct_data), .ct_valid(z_ct_valid), .ct_ready(z_ct_ready),
        .busy(z_busy), .word_cnt(z_word_cnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Pulse start for one edge; returns the cycle stamp of that edge.
    task automatic do_start(output int stamp);
        start = 1'b1;
        tick();
        start = 1'b0;
        stamp = cyc;
    endtask

    // Send n bits MSB-first, with 'gap' idle cycles after each accepted bit.
    task automatic send_bits(input logic [15:0] bits, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int t;
            ks_bit   = bits[n-1-i];
            ks_valid = 1'b1;
            t = 0;
            while (!ks_ready && t < 100) begin
                tick();
                t++;
            end
            check("ks_ready_wait", {31'd0, ks_ready}, 32'd1);
            tick();
            ks_valid = 1'b0;
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic wait_ct();
        int t;
        t = 0;
        while (!ct_valid && t < 200) begin
            tick();
            t++;
        end
        check("ct_valid_wait", {31'd0, ct_valid}, 32'd1);
    endtask

    task automatic send_bits_z(input logic [7:0] bits);
        for (int i = 0; i < 8; i++) begin
            int t;
            z_ks_bit   = bits[7-i];
            z_ks_valid = 1'b1;
            t = 0;
            while (!z_ks_ready && t < 100) begin
                tick();
                t++;
            end
            check("z_ks_ready_wait", {31'd0, z_ks_ready}, 32'd1);
            tick();
            z_ks_valid = 1'b0;
        end
    endtask

    task automatic wait_ct_z();
        int t;
        t = 0;
        while (!z_ct_valid && t < 200) begin
            tick();
            t++;
        end
        check("z_ct_valid_wait", {31'd0, z_ct_valid}, 32'd1);
    endtask

    initial begin
        int s;

        reset = 1'b0; start = 1'b0; stop = 1'b0; ks_bit = 1'b0; ks_valid = 1'b0;
        pt_data = 8'h00; pt_valid = 1'b0; ct_ready = 1'b0;
        z_reset = 1'b0; z_start = 1'b0; z_stop = 1'b0; z_ks_bit = 1'b0; z_ks_valid = 1'b0;
        z_pt_data = 8'h00; z_pt_valid = 1'b0; z_ct_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_ct_valid", {31'd0, ct_valid}, 32'd0);
        check("rst_ct_data",  {24'd0, ct_data},  32'd0);
        check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        check("rst_ks_ready", {31'd0, ks_ready}, 32'd0);
        check("rst_pt_ready", {31'd0, pt_ready}, 32'd0);
        reset = 1'b1;

        // Basic encrypt: A5 ^ 3C = 99, latency 4+8+2 = 14
        pt_data = 8'h3C; pt_valid = 1'b1; ct_ready = 1'b1;
        do_start(s);
        check("basic_busy",     {31'd0, busy},     32'd1);
        check("basic_ks_ready", {31'd0, ks_ready}, 32'd1);
        check("basic_pt_ready", {31'd0, pt_ready}, 32'd0);
        send_bits(16'b1011, 4, 0);
        send_bits(16'hA5, 8, 0);
        check("basic_wait_pt_ready", {31'd0, pt_ready}, 32'd1);
        check("basic_wait_ks_ready", {31'd0, ks_ready}, 32'd0);
        wait_ct();
        check("basic_latency", cyc - s + 1, 32'd14);
        check("basic_ct_data", {24'd0, ct_data}, 32'h99);
        tick();
        check("basic_ct_valid_drop", {31'd0, ct_valid}, 32'd0);
        check("basic_word_cnt",      {16'd0, word_cnt}, 32'd1);
        check("basic_refill_ks",     {31'd0, ks_ready}, 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("basic_stop_busy", {31'd0, busy}, 32'd0);

        // Backpressure: ct_ready low for 5 cycles while ct_valid is high
        do_reset();
        ct_ready = 1'b0;
        do_start(s);
        send_bits(16'b1011, 4, 0);
        send_bits(16'hA5, 8, 0);
        wait_ct();
        for (int k = 0; k < 5; k++) begin
            check("bp_ct_data",  {24'd0, ct_data},  32'h99);
            check("bp_ct_valid", {31'd0, ct_valid}, 32'd1);
            check("bp_ks_ready", {31'd0, ks_ready}, 32'd0);
            check("bp_pt_ready", {31'd0, pt_ready}, 32'd0);
            tick();
        end
        ct_ready = 1'b1;
        tick();
        check("bp_ct_valid_drop", {31'd0, ct_valid}, 32'd0);
        check("bp_word_cnt",      {16'd0, word_cnt}, 32'd1);

        // stop overrides a simultaneous ct transfer: FF ^ 3C = C3
        ct_ready = 1'b0;
        send_bits(16'hFF, 8, 0);
        wait_ct();
        check("ovr_ct_data", {24'd0, ct_data}, 32'hC3);
        ct_ready = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("ovr_word_cnt", {16'd0, word_cnt}, 32'd1);
        check("ovr_ct_valid", {31'd0, ct_valid}, 32'd0);
        check("ovr_busy",     {31'd0, busy},     32'd0);

        // Keystream stalls: one idle cycle after each bit, latency 2*12+1 = 25
        do_reset();
        do_start(s);
        send_bits(16'b1011, 4, 1);
        send_bits(16'hA5, 8, 1);
        wait_ct();
        check("stall_latency", cyc - s + 1, 32'd25);
        check("stall_ct_data", {24'd0, ct_data}, 32'h99);
        tick();

        // Abort in FILL after 3 bits, then a fresh session: 0F ^ 3C = 33
        do_reset();
        do_start(s);
        send_bits(16'b1011, 4, 0);
        send_bits(16'b111, 3, 0);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("abort_busy",     {31'd0, busy},     32'd0);
        check("abort_ks_ready", {31'd0, ks_ready}, 32'd0);
        tick();
        tick();
        check("abort_ct_valid", {31'd0, ct_valid}, 32'd0);
        do_start(s);
        send_bits(16'b0110, 4, 0);
        send_bits(16'h0F, 8, 0);
        wait_ct();
        check("abort_restart_latency", cyc - s + 1, 32'd14);
        check("abort_restart_ct_data", {24'd0, ct_data}, 32'h33);
        tick();
        check("abort_restart_word_cnt", {16'd0, word_cnt}, 32'd1);

        // Reset mid-OUT with start held during reset
        ct_ready = 1'b0;
        send_bits(16'hA5, 8, 0);
        wait_ct();
        check("rmo_ct_data_before", {24'd0, ct_data}, 32'h99);
        reset = 1'b0;
        start = 1'b1;
        tick();
        check("rmo_ct_valid", {31'd0, ct_valid}, 32'd0);
        check("rmo_ct_data",  {24'd0, ct_data},  32'd0);
        check("rmo_word_cnt", {16'd0, word_cnt}, 32'd0);
        check("rmo_busy",     {31'd0, busy},     32'd0);
        tick();
        check("rmo_busy_start_held", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        start = 1'b0;
        tick();
        check("rmo_busy_after", {31'd0, busy}, 32'd0);

        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", {31'd0, busy}, 32'd0);
        tick();
        check("ss_busy_later", {31'd0, busy}, 32'd0);

        // WARMUP=0: first bit lands in bit 7; latency 0+8+2 = 10
        z_reset = 1'b1;
        z_pt_valid = 1'b1;
        z_pt_data  = 8'h00;
        z_ct_ready = 1'b1;
        z_start = 1'b1;
        tick();
        z_start = 1'b0;
        s = cyc;
        send_bits_z(8'h80);
        wait_ct_z();
        check("z_latency", cyc - s + 1, 32'd10);
        check("z_ct_data_msb", {24'd0, z_ct_data}, 32'h80);
        tick();
        check("z_word_cnt_1", {30'd0, z_word_cnt}, 32'd1);

        // Four more words on a 2-bit counter: 2, 3, 0 (wrap), 1
        z_pt_data = 8'hF0;
        send_bits_z(8'h5A);
        wait_ct_z();
        check("z_ct_data_w2", {24'd0, z_ct_data}, 32'hAA);
        tick();
        check("z_word_cnt_2", {30'd0, z_word_cnt}, 32'd2);
        send_bits_z(8'h01);
        wait_ct_z();
        check("z_ct_data_w3", {24'd0, z_ct_data}, 32'hF1);
        tick();
        check("z_word_cnt_3", {30'd0, z_word_cnt}, 32'd3);
        send_bits_z(8'hFF);
        wait_ct_z();
        check("z_ct_data_w4", {24'd0, z_ct_data}, 32'h0F);
        tick();
        check("z_word_cnt_wrap", {30'd0, z_word_cnt}, 32'd0);
        send_bits_z(8'h33);
        wait_ct_z();
        check("z_ct_data_w5", {24'd0, z_ct_data}, 32'hC3);
        tick();
        check("z_word_cnt_5", {30'd0, z_word_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
